// File: rtl/pattern_det_ctrl.sv
// pattern_det_ctrl
//   Serial pattern detector with run control. A run starts on `start`. Each
//   qualified input bit is shifted into a history register. A match is
//   declared when at least PAT_W bits have been collected and the newest
//   PAT_W bits equal the configured pattern (MSB = oldest bit). Matches are
//   counted, and a nonzero target count ends the run through a one-cycle
//   DONE state.
//
// Optional feature: define PATDET_TIMEOUT_EN to add a run timeout. If no
//   match is seen for 2^TMO_W-1 RUN cycles, the sticky `timeout` flag is set
//   and the run ends through DONE. Without the macro there is no timeout
//   counter and `timeout` is tied to 0.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   cfg_we       config write strobe (honoured only in IDLE)
//   cfg_pattern  pattern to detect, MSB received first
//   cfg_overlap  1 = overlapping matches, 0 = non-overlapping
//   cfg_target   match count that ends a run, 0 = unlimited
//   start        begin a run (IDLE only)
//   abort        end a run immediately (RUN only), wins over a match
//   in_valid     qualifies `in`
//   in           serial data bit
//   busy         high while in RUN
//   det          one-cycle registered match pulse
//   done         high for the single DONE cycle
//   match_cnt    matches in the current/last run, saturating
//   timeout      sticky timeout flag for the current/last run
//
// state | meaning
// IDLE  | waiting for start, config writable
// RUN   | shifting qualified bits, counting matches
// DONE  | run completed, done high for one cycle

module pattern_det_ctrl #(
    parameter int PAT_W = 4,
    parameter int CNT_W = 8,
    parameter int TMO_W = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic             start,
    input  logic             abort,
    input  logic             in_valid,
    input  logic             in,
    output logic             busy,
    output logic             det,
    output logic             done,
    output logic [CNT_W-1:0] match_cnt,
    output logic             timeout
);

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [PAT_W-1:0]    pat_q, pat_d;
    logic                ovl_q, ovl_d;
    logic [CNT_W-1:0]    tgt_q, tgt_d;
    logic [PAT_W-1:0]    hist_q, hist_d;
    logic [FILL_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                det_q, det_d;

    logic [PAT_W-1:0]    hist_new;
    logic [FILL_W-1:0]   fill_inc;
    logic                hit;

`ifdef PATDET_TIMEOUT_EN
    // Down-counter reloaded on start and on every match; terminal count 1
    // means this is the (2^TMO_W-1)th RUN cycle without a match.
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                timeout_q, timeout_d;
`endif

    // Candidate history/fill as if the current bit were accepted.
    assign hist_new = {hist_q[PAT_W-2:0], in};
    assign fill_inc = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
    assign hit      = in_valid && (fill_inc == FILL_FULL) && (hist_new == pat_q);

    always_comb begin
        state_d = state_q;
        pat_d   = pat_q;
        ovl_d   = ovl_q;
        tgt_d   = tgt_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        cnt_d   = cnt_q;
        det_d   = 1'b0;
`ifdef PATDET_TIMEOUT_EN
        tmo_d     = tmo_q;
        timeout_d = timeout_q;
`endif
        case (state_q)
            IDLE: begin
                if (cfg_we) begin
                    pat_d = cfg_pattern;
                    ovl_d = cfg_overlap;
                    tgt_d = cfg_target;
                end
                if (start) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    hist_d  = '0;
                    fill_d  = '0;
`ifdef PATDET_TIMEOUT_EN
                    tmo_d     = '1;
                    timeout_d = 1'b0;
`endif
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    if (in_valid) begin
                        hist_d = hist_new;
                        fill_d = fill_inc;
                    end
                    if (hit) begin
                        det_d = 1'b1;
                        cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                        // Non-overlapping: the matched bits may not seed the next match.
                        if (!ovl_q) begin
                            fill_d = '0;
                        end
`ifdef PATDET_TIMEOUT_EN
                        tmo_d = '1;
`endif
                        if ((tgt_q != '0) && (cnt_d == tgt_q)) begin
                            state_d = DONE;
                        end
                    end
`ifdef PATDET_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(1)) begin
                        timeout_d = 1'b1;
                        state_d   = DONE;
                    end else begin
                        tmo_d = tmo_q - 1'b1;
                    end
`endif
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pat_q   <= '0;
            ovl_q   <= 1'b0;
            tgt_q   <= '0;
            hist_q  <= '0;
            fill_q  <= '0;
            cnt_q   <= '0;
            det_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            ovl_q   <= ovl_d;
            tgt_q   <= tgt_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            cnt_q   <= cnt_d;
            det_q   <= det_d;
        end
    end

`ifdef PATDET_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q     <= '1;
            timeout_q <= 1'b0;
        end else begin
            tmo_q     <= tmo_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign busy      = (state_q == RUN);
    assign done      = (state_q == DONE);
    assign det       = det_q;
    assign match_cnt = cnt_q;

endmodule
